// File: rtl/sp_ram_pkg.sv
// Shared types and byte-enable helper for the single-port RAM initiator.
package sp_ram_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC0 = 3'd1,
        ACC1 = 3'd2,
        CAPT = 3'd3,
        RSP  = 3'd4
    } state_e;

    // Access width in bytes; 0 marks the illegal size encoding.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: nbytes = 3'd1;
            SZ_HALF: nbytes = 3'd2;
            SZ_WORD: nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
    endfunction

    // Returns {be_lo, be_hi}: enables for the first word and for the spill into the next word.
    function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [7:0] span;
        span    = ((8'd1 << nbytes(size)) - 8'd1) << offset;
        be_mask = {span[3:0], span[7:4]};
    endfunction

endpackage

// File: rtl/sp_ram_align.sv
// Combinational lane steering: store data shift onto byte lanes, load byte extract and extend.
module sp_ram_align
    import sp_ram_pkg::*;
(
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_wdata,
    output logic [63:0] st_lanes,
    input  logic [63:0] ld_words,
    input  logic [1:0]  ld_offset,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;
    logic        sign_bit;

    always_comb begin
        st_lanes   = {32'd0, st_wdata} << {st_offset, 3'b000};
        ld_shifted = 32'(ld_words >> {ld_offset, 3'b000});
        ld_data    = ld_shifted;
        sign_bit   = 1'b0;
        case (ld_size)
            SZ_BYTE: begin
                sign_bit = ~ld_unsigned & ld_shifted[7];
                ld_data  = {{24{sign_bit}}, ld_shifted[7:0]};
            end
            SZ_HALF: begin
                sign_bit = ~ld_unsigned & ld_shifted[15];
                ld_data  = {{16{sign_bit}}, ld_shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sp_ram_initiator.sv
// Single-port RAM initiator: one outstanding byte/half/word load or store.
// Word-spanning (split) accesses exist only when SP_RAM_MISALIGNED_EN is defined.
module sp_ram_initiator
    import sp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    output logic [3:0]            ram_be_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    localparam int WAW = ADDR_WIDTH - 2;

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("sp_ram_initiator supports DATA_WIDTH = 32 only");
    end

    state_e                state_q, state_d;
    logic                  we_q, uns_q, err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic [31:0]           wdata_q, rdata_q;
`ifdef SP_RAM_MISALIGNED_EN
    logic [31:0]           buf_q;
`endif

    logic                  ram_en_q, ram_we_q, ram_en_d, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]           ram_wdata_q, ram_wdata_d;
    logic [3:0]            ram_be_q, ram_be_d;

    logic                  accept, cur_we, cur_err, cur_split;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [WAW-1:0]        cur_waddr;
    logic [1:0]            cur_size, cur_off;
    logic [2:0]            cur_nb;
    logic [7:0]            cur_be;
    logic [31:0]           cur_wdata, ld_data;
    logic [63:0]           st_lanes, ld_words;

    assign req_ready_o = (state_q == IDLE) && !rst_i;
    assign rsp_valid_o = (state_q == RSP) && !rst_i;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign accept      = req_valid_i && req_ready_o;
    assign ram_en_o    = ram_en_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign ram_be_o    = ram_be_q;

    // While idle the live request is decoded so the first access can be registered on the accept edge.
    always_comb begin
        cur_we    = (state_q == IDLE) ? req_we_i    : we_q;
        cur_addr  = (state_q == IDLE) ? req_addr_i  : addr_q;
        cur_size  = (state_q == IDLE) ? req_size_i  : size_q;
        cur_wdata = (state_q == IDLE) ? req_wdata_i : wdata_q;
        cur_off   = cur_addr[1:0];
        cur_waddr = cur_addr[ADDR_WIDTH-1:2];
        cur_nb    = nbytes(cur_size);
        cur_be    = be_mask(cur_size, cur_off);
        cur_err   = (cur_size == 2'd3);
`ifdef SP_RAM_MISALIGNED_EN
        cur_split = ({1'b0, cur_off} + cur_nb) > 3'd4;
`else
        cur_split = 1'b0;
        if ((cur_off & 2'(cur_nb - 3'd1)) != 2'b00) cur_err = 1'b1;
`endif
    end

    always_comb begin
`ifdef SP_RAM_MISALIGNED_EN
        ld_words = cur_split ? {ram_rdata_i, buf_q} : {32'd0, ram_rdata_i};
`else
        ld_words = {32'd0, ram_rdata_i};
`endif
    end

    sp_ram_align u_align (
        .st_offset   (cur_off),
        .st_wdata    (cur_wdata),
        .st_lanes    (st_lanes),
        .ld_words    (ld_words),
        .ld_offset   (addr_q[1:0]),
        .ld_size     (size_q),
        .ld_unsigned (uns_q),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = cur_err ? RSP : ACC0;
            ACC0: begin
                if (cur_split)   state_d = ACC1;
                else if (cur_we) state_d = RSP;
                else             state_d = CAPT;
            end
            ACC1: state_d = cur_we ? RSP : CAPT;
            CAPT: state_d = RSP;
            RSP:  if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM pins are a function of the state being entered, so they are registered outputs.
    always_comb begin
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        ram_be_d    = '0;
        if (state_d == ACC0) begin
            ram_en_d    = 1'b1;
            ram_we_d    = cur_we;
            ram_addr_d  = {cur_waddr, 2'b00};
            ram_be_d    = cur_be[7:4];
            ram_wdata_d = st_lanes[31:0];
        end else if (state_d == ACC1) begin
            ram_en_d    = 1'b1;
            ram_we_d    = cur_we;
            ram_addr_d  = {cur_waddr + WAW'(1), 2'b00};
            ram_be_d    = cur_be[3:0];
            ram_wdata_d = st_lanes[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_be_q    <= '0;
`ifdef SP_RAM_MISALIGNED_EN
            buf_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_be_q    <= ram_be_d;
            if (accept) begin
                we_q    <= req_we_i;
                uns_q   <= req_unsigned_i;
                addr_q  <= req_addr_i;
                size_q  <= req_size_i;
                wdata_q <= req_wdata_i;
                rdata_q <= '0;
                err_q   <= cur_err;
            end
`ifdef SP_RAM_MISALIGNED_EN
            if (state_q == ACC1 && !we_q) buf_q <= ram_rdata_i;
`endif
            if (state_q == CAPT) rdata_q <= ld_data;
        end
    end

endmodule

// File: tb/tb_sp_ram_initiator.sv
// Bench for sp_ram_initiator with a word RAM model and a byte-array reference of memory contents.
// Honours SP_RAM_MISALIGNED_EN the same way the design does.
module tb_sp_ram_initiator;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [AW-1:0] req_addr_i;
    logic [1:0]    req_size_i;
    logic [31:0]   req_wdata_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0]   rsp_rdata_o;
    logic          ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_wdata_o;
    logic [3:0]    ram_be_o;
    logic [31:0]   ram_rdata_i = 32'h5A5A_5A5A;

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    sp_ram_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .ram_en_o       (ram_en_o),
        .ram_we_o       (ram_we_o),
        .ram_addr_o     (ram_addr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_be_o       (ram_be_o),
        .ram_rdata_i    (ram_rdata_i)
    );

    // ---------------- RAM model: one-cycle read latency, byte-enabled writes ----------------
    logic [31:0] ram_mem [64] = '{default: 32'h0};

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] w;
        w = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = new_w[8*b +: 8];
        return w;
    endfunction

    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) ram_mem[ram_addr_o[7:2]] <= merge(ram_mem[ram_addr_o[7:2]], ram_wdata_o, ram_be_o);
            else          ram_rdata_i <= ram_mem[ram_addr_o[7:2]];
        end
    end

    // RAM access log
    logic [AW-1:0] acc_addr_q[$];
    logic [3:0]    acc_be_q[$];
    logic [31:0]   acc_wd_q[$];

    always @(negedge clk) begin
        if (ram_en_o) begin
            acc_addr_q.push_back(ram_addr_o);
            acc_be_q.push_back(ram_be_o);
            acc_wd_q.push_back(ram_wdata_o);
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [7:0]  ref_mem [256];
    logic [32:0] exp_q[$];
    int          last_base;

    function automatic int nbytes_of(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_txn(input logic we, input logic [7:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] wdata,
                             output int lat, output int nacc);
        int          nb;
        logic        err, split;
        logic [31:0] v;
        nb  = nbytes_of(size);
        err = (size == 2'd3);
`ifndef SP_RAM_MISALIGNED_EN
        if (!err && (int'(addr) % nb) != 0) err = 1'b1;
`endif
        split = !err && (int'(addr[1:0]) + nb > 4);
        v     = 32'd0;
        lat   = 1;
        nacc  = 0;
        if (!err) begin
            nacc = split ? 2 : 1;
            if (we) begin
                for (int i = 0; i < nb; i++) ref_mem[8'(int'(addr) + i)] = wdata[8*i +: 8];
                lat = split ? 3 : 2;
            end else begin
                for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[8'(int'(addr) + i)];
                if (!uns && v[8*nb-1])
                    for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
                lat = split ? 4 : 3;
            end
        end
        exp_q.push_back({err, v});
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_acc(input string tag, input int idx, input logic [AW-1:0] addr,
                             input logic [3:0] be, input logic [31:0] wd);
        if (idx < acc_addr_q.size()) begin
            check({tag, "/addr"}, 32'(acc_addr_q[idx]), 32'(addr));
            check({tag, "/be"}, 32'(acc_be_q[idx]), 32'(be));
            check({tag, "/wdata"}, acc_wd_q[idx], wd);
        end else begin
            check({tag, "/present"}, 32'(acc_addr_q.size()), 32'(idx + 1));
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_req(input string tag, input logic we, input logic [7:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                          input int stall, output logic [31:0] got);
        int          exp_lat, exp_nacc, t;
        logic [32:0] e;
        logic [31:0] held;
        model_txn(we, addr, size, uns, wdata, exp_lat, exp_nacc);
        @(negedge clk);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_addr_i     = addr;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_wdata_i    = wdata;
        rsp_ready_i    = (stall == 0);
        t = 0;
        while (!req_ready_o && t < 20) begin @(negedge clk); t++; end
        check({tag, "/ready"}, 32'(req_ready_o), 32'd1);
        last_base = acc_addr_q.size();
        @(negedge clk);
        req_valid_i = 1'b0;
        t = 1;
        while (!rsp_valid_o && t < 20) begin @(negedge clk); t++; end
        check({tag, "/lat"}, 32'(t), 32'(exp_lat));
        e = exp_q.pop_front();
        check({tag, "/rdata"}, rsp_rdata_o, e[31:0]);
        check({tag, "/err"}, 32'(rsp_err_o), 32'(e[32]));
        check({tag, "/nacc"}, 32'(acc_addr_q.size() - last_base), 32'(exp_nacc));
        got  = rsp_rdata_o;
        held = rsp_rdata_o;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "/hold_valid"}, 32'(rsp_valid_o), 32'd1);
            check({tag, "/hold_rdata"}, rsp_rdata_o, held);
            check({tag, "/hold_noready"}, 32'(req_ready_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
    endtask

    // ---------------- directed then random sequence ----------------
    logic [31:0] got;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        rst_i          = 1'b1;
        req_valid_i    = 1'b0;
        req_we_i       = 1'b0;
        req_addr_i     = '0;
        req_size_i     = 2'd0;
        req_unsigned_i = 1'b0;
        req_wdata_i    = 32'd0;
        rsp_ready_i    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst/req_ready", 32'(req_ready_o), 32'd0);
        check("rst/rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst/ram_en", 32'(ram_en_o), 32'd0);
        check("rst/rsp_rdata", rsp_rdata_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk);
        check("rst/ready_after", 32'(req_ready_o), 32'd1);

        do_req("st_w", 1'b1, 8'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, got);
        check_acc("st_w/acc", last_base, 8'h10, 4'b1111, 32'hDEADBEEF);
        do_req("ld_w", 1'b0, 8'h10, 2'd2, 1'b0, 32'd0, 0, got);
        check("ld_w/const", got, 32'hDEADBEEF);

        do_req("st_b", 1'b1, 8'h13, 2'd0, 1'b0, 32'h000000A5, 0, got);
        check_acc("st_b/acc", last_base, 8'h10, 4'b1000, 32'hA5000000);
        do_req("ld_bs", 1'b0, 8'h13, 2'd0, 1'b0, 32'd0, 0, got);
        check("ld_bs/const", got, 32'hFFFFFFA5);
        do_req("ld_bu", 1'b0, 8'h13, 2'd0, 1'b1, 32'd0, 0, got);
        check("ld_bu/const", got, 32'h000000A5);

        do_req("st_h", 1'b1, 8'h22, 2'd1, 1'b0, 32'h00008001, 0, got);
        check_acc("st_h/acc", last_base, 8'h20, 4'b1100, 32'h80010000);
        do_req("ld_hs", 1'b0, 8'h22, 2'd1, 1'b0, 32'd0, 0, got);
        check("ld_hs/const", got, 32'hFFFF8001);
        do_req("ld_hu", 1'b0, 8'h22, 2'd1, 1'b1, 32'd0, 0, got);
        check("ld_hu/const", got, 32'h00008001);

        do_req("st_split", 1'b1, 8'h0E, 2'd2, 1'b0, 32'h11223344, 0, got);
`ifdef SP_RAM_MISALIGNED_EN
        check_acc("st_split/acc0", last_base, 8'h0C, 4'b1100, 32'h33440000);
        check_acc("st_split/acc1", last_base + 1, 8'h10, 4'b0011, 32'h00001122);
        do_req("ld_split", 1'b0, 8'h0E, 2'd2, 1'b0, 32'd0, 0, got);
        check("ld_split/const", got, 32'h11223344);
        do_req("ld_wrap", 1'b0, 8'hFE, 2'd2, 1'b0, 32'd0, 0, got);
        check_acc("ld_wrap/acc0", last_base, 8'hFC, 4'b1100, 32'h0);
        check_acc("ld_wrap/acc1", last_base + 1, 8'h00, 4'b0011, 32'h0);
`else
        check("st_split/err_const", 32'(rsp_err_o), 32'd1);
`endif

        do_req("bad_size", 1'b0, 8'h40, 2'd3, 1'b0, 32'd0, 0, got);
        do_req("bp_load", 1'b0, 8'h10, 2'd2, 1'b0, 32'd0, 5, got);

        // Reset while the first access of a load is on the RAM pins.
        @(negedge clk);
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 8'h10;
        req_size_i  = 2'd2;
        @(negedge clk);
        req_valid_i = 1'b0;
        check("mid_rst/acc0_en", 32'(ram_en_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk);
        check("mid_rst/ram_en", 32'(ram_en_o), 32'd0);
        check("mid_rst/ram_we", 32'(ram_we_o), 32'd0);
        check("mid_rst/ram_addr", 32'(ram_addr_o), 32'd0);
        check("mid_rst/ram_wdata", ram_wdata_o, 32'd0);
        check("mid_rst/ram_be", 32'(ram_be_o), 32'd0);
        check("mid_rst/rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("mid_rst/rsp_err", 32'(rsp_err_o), 32'd0);
        check("mid_rst/rsp_rdata", rsp_rdata_o, 32'd0);
        check("mid_rst/req_ready", 32'(req_ready_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk);
        check("mid_rst/ready_after", 32'(req_ready_o), 32'd1);
        check("mid_rst/no_rsp", 32'(rsp_valid_o), 32'd0);

        for (int n = 0; n < 150; n++) begin
            logic       r_we, r_uns;
            logic [7:0] r_addr;
            logic [1:0] r_size;
            int         r_sel, r_stall;
            r_we   = 1'($urandom_range(0, 1));
            r_uns  = 1'($urandom_range(0, 1));
            r_addr = 8'($urandom_range(0, 255));
            r_sel  = $urandom_range(0, 9);
            r_size = (r_sel < 3) ? 2'd0 : (r_sel < 6) ? 2'd1 : (r_sel < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 1) == 1 && r_size == 2'd1) r_addr[0] = 1'b0;
            if ($urandom_range(0, 1) == 1 && r_size == 2'd2) r_addr[1:0] = 2'b00;
            r_stall = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
            do_req("rnd", r_we, r_addr, r_size, r_uns, $urandom, r_stall, got);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
